// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM: fetch/decode/execute/memory/writeback
// with a bounded multiplier wait and illegal-instruction reporting.
module multicycle_controller (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       mem_ready,
  input  logic       mul_done,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       PCWriteCond,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic       ALUSrc2,
  output logic       RegSl,
  output logic       mul_start,
  output logic       illegal,
  output logic [3:0] ALUOp,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MEMACC  = 3'd3,
    S_WB      = 3'd4,
    S_MULWAIT = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    K_ILL = 3'd0,
    K_ALU = 3'd1,
    K_MUL = 3'd2,
    K_LW  = 3'd3,
    K_SW  = 3'd4,
    K_BNE = 3'd5
  } kind_t;

  typedef struct packed {
    kind_t      kind;
    logic [3:0] aluop;
    logic       alusrc;
    logic       alusrc2;
    logic       regsl;
    logic       regdst;
    logic       memtoreg;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
    dec_t d;
    d.kind     = K_ALU;
    d.aluop    = 4'b0000;
    d.alusrc   = 1'b0;
    d.alusrc2  = 1'b0;
    d.regsl    = 1'b0;
    d.regdst   = 1'b0;
    d.memtoreg = 1'b0;
    case (op)
      6'b000000: begin
        d.regdst = 1'b1;
        case (fn)
          6'b100000: d.aluop = 4'b0000;
          6'b100010: d.aluop = 4'b0001;
          6'b100100: d.aluop = 4'b0011;
          6'b100101: d.aluop = 4'b0100;
          6'b101010: d.aluop = 4'b0101;
          6'b000000: begin d.aluop = 4'b1000; d.alusrc2 = 1'b1; d.regsl = 1'b1; end
          6'b000010: begin d.aluop = 4'b1001; d.alusrc2 = 1'b1; d.regsl = 1'b1; end
          6'b000110: d.aluop = 4'b1010;
          default:   d.kind = K_ILL;
        endcase
      end
      6'b011100: begin
        d.regdst = 1'b1;
        case (fn)
          6'b100001: d.aluop = 4'b1011;
          6'b100000: d.aluop = 4'b1100;
          6'b000010: begin d.aluop = 4'b0010; d.kind = K_MUL; end
          default:   d.kind = K_ILL;
        endcase
      end
      6'b001000: d.alusrc = 1'b1;
      6'b001101: begin d.aluop = 4'b0100; d.alusrc = 1'b1; end
      6'b100011: begin d.kind = K_LW; d.alusrc = 1'b1; d.memtoreg = 1'b1; end
      6'b101011: begin d.kind = K_SW; d.alusrc = 1'b1; end
      6'b000101: begin d.kind = K_BNE; d.aluop = 4'b0110; d.regdst = 1'b1; end
      default:   d.kind = K_ILL;
    endcase
    // Illegal encodings carry no datapath controls at all.
    if (d.kind == K_ILL) begin
      d.aluop    = 4'b0000;
      d.alusrc2  = 1'b0;
      d.regsl    = 1'b0;
      d.regdst   = 1'b0;
    end
    return d;
  endfunction

  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
    dec_t d;
    d = decode(op, fn);
    return d.kind;
  endfunction

  state_t     state_q, state_d;
  logic [5:0] op_q, fn_q;
  logic [4:0] cnt_q, cnt_d;
  kind_t      kind_now;
  dec_t       dec_q;
  logic       dp_en;

  assign kind_now = classify(opcode, func);
  assign dec_q    = decode(op_q, fn_q);
  assign state    = state_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      fn_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        fn_q <= func;
      end
    end
  end

  always_comb begin
    state_d     = S_FETCH;
    cnt_d       = cnt_q;
    PCWrite     = 1'b0;
    IRWrite     = 1'b0;
    PCWriteCond = 1'b0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    ALUSrc      = 1'b0;
    ALUSrc2     = 1'b0;
    RegSl       = 1'b0;
    mul_start   = 1'b0;
    illegal     = 1'b0;
    ALUOp       = 4'b0000;
    dp_en       = 1'b0;

    case (state_q)
      S_FETCH: begin
        PCWrite = 1'b1;
        IRWrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (kind_now)
          K_ILL: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
          K_MUL: begin
            mul_start = 1'b1;
            cnt_d     = 5'd0;
            state_d   = S_MULWAIT;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        dp_en = 1'b1;
        case (dec_q.kind)
          K_ALU:      state_d = S_WB;
          K_LW, K_SW: state_d = S_MEMACC;
          K_BNE: begin
            PCWriteCond = 1'b1;
            state_d     = S_FETCH;
          end
          default:    state_d = S_FETCH;
        endcase
      end
      S_MEMACC: begin
        dp_en    = 1'b1;
        MemRead  = (dec_q.kind == K_LW);
        MemWrite = (dec_q.kind == K_SW);
        if (!MemRead && !MemWrite) state_d = S_FETCH;
        else if (!mem_ready)       state_d = S_MEMACC;
        else if (MemRead)          state_d = S_WB;
        else                       state_d = S_FETCH;
      end
      S_MULWAIT: begin
        dp_en = 1'b1;
        if (mul_done) begin
          state_d = S_WB;
        end else if (cnt_q == 5'd31) begin
          // 32nd cycle without a result: give up and report it.
          illegal = 1'b1;
          state_d = S_FETCH;
        end else begin
          cnt_d   = cnt_q + 5'd1;
          state_d = S_MULWAIT;
        end
      end
      S_WB: begin
        dp_en    = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (dp_en) begin
      ALUOp    = dec_q.aluop;
      ALUSrc   = dec_q.alusrc;
      ALUSrc2  = dec_q.alusrc2;
      RegSl    = dec_q.regsl;
      RegDst   = dec_q.regdst;
      MemtoReg = dec_q.memtoreg;
    end

    // Reset silences every control immediately, before the edge lands.
    if (Rst) begin
      PCWrite     = 1'b0;
      IRWrite     = 1'b0;
      PCWriteCond = 1'b0;
      RegWrite    = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      ALUSrc      = 1'b0;
      ALUSrc2     = 1'b0;
      RegSl       = 1'b0;
      mul_start   = 1'b0;
      illegal     = 1'b0;
      ALUOp       = 4'b0000;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: every cycle's expected state and
// control word is queued by the driver and checked by a negedge monitor.
module tb_multicycle_controller;

  logic       Clk;
  logic       Rst;
  logic [5:0] opcode, func;
  logic       mem_ready, mul_done;
  logic       PCWrite, IRWrite, PCWriteCond, RegWrite, MemRead, MemWrite;
  logic       MemtoReg, RegDst, ALUSrc, ALUSrc2, RegSl, mul_start, illegal;
  logic [3:0] ALUOp;
  logic [2:0] state;

  multicycle_controller dut (
    .Clk(Clk), .Rst(Rst), .opcode(opcode), .func(func),
    .mem_ready(mem_ready), .mul_done(mul_done),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .PCWriteCond(PCWriteCond),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUSrc2(ALUSrc2),
    .RegSl(RegSl), .mul_start(mul_start), .illegal(illegal),
    .ALUOp(ALUOp), .state(state)
  );

  // Flag word order: PCWrite IRWrite PCWriteCond RegWrite MemRead MemWrite
  // MemtoReg RegDst ALUSrc ALUSrc2 RegSl mul_start illegal
  localparam logic [12:0] PCW = 13'h1000, IRW = 13'h0800, PWC = 13'h0400;
  localparam logic [12:0] RW  = 13'h0200, MR  = 13'h0100, MW  = 13'h0080;
  localparam logic [12:0] M2R = 13'h0040, RD  = 13'h0020, AS  = 13'h0010;
  localparam logic [12:0] AS2 = 13'h0008, RSL = 13'h0004, MST = 13'h0002;
  localparam logic [12:0] ILL = 13'h0001;
  localparam logic [12:0] NONE = 13'h0000;

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // scoreboard
  logic [19:0] exp_q[$];
  string       tag_q[$];
  int          total = 0;
  int          bad   = 0;

  always @(negedge Clk) begin
    logic [19:0] act, exp;
    string       tag;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      tag = tag_q.pop_front();
      act = {state, ALUOp, PCWrite, IRWrite, PCWriteCond, RegWrite, MemRead,
             MemWrite, MemtoReg, RegDst, ALUSrc, ALUSrc2, RegSl, mul_start, illegal};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL %s @%0t: state/aluop/flags got %b want %b", tag, $time, act, exp);
      end
    end
  end

  // driver tasks
  function automatic logic [5:0] rnd6();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc(input logic rst, input logic [5:0] opc, input logic [5:0] fn,
                     input logic mr, input logic md, input logic [2:0] st,
                     input logic [3:0] aop, input logic [12:0] fl, input string tag);
    @(posedge Clk);
    #1;
    Rst       = rst;
    opcode    = opc;
    func      = fn;
    mem_ready = mr;
    mul_done  = md;
    exp_q.push_back({st, aop, fl});
    tag_q.push_back(tag);
  endtask

  task automatic run_fetch(input string tag);
    cyc(1'b0, rnd6(), rnd6(), rnd1(), rnd1(), 3'd0, 4'h0, PCW | IRW, {tag, "_fetch"});
  endtask

  task automatic run_alu(input logic [5:0] opc, input logic [5:0] fn, input logic [3:0] aop,
                         input logic [12:0] fl, input string tag);
    run_fetch(tag);
    cyc(1'b0, opc, fn, 1'b0, 1'b0, 3'd1, 4'h0, NONE, {tag, "_decode"});
    cyc(1'b0, rnd6(), rnd6(), 1'b1, 1'b1, 3'd2, aop, fl, {tag, "_exec"});
    cyc(1'b0, rnd6(), rnd6(), 1'b1, 1'b1, 3'd4, aop, fl | RW, {tag, "_wb"});
  endtask

  task automatic run_mem(input logic is_lw, input int waits, input string tag);
    logic [5:0]  opc;
    logic [12:0] fl, acc;
    opc = is_lw ? 6'h23 : 6'h2b;
    fl  = is_lw ? (AS | M2R) : AS;
    acc = is_lw ? MR : MW;
    run_fetch(tag);
    cyc(1'b0, opc, rnd6(), 1'b0, 1'b1, 3'd1, 4'h0, NONE, {tag, "_decode"});
    cyc(1'b0, rnd6(), rnd6(), 1'b1, 1'b1, 3'd2, 4'h0, fl, {tag, "_exec"});
    for (int i = 0; i < waits; i++)
      cyc(1'b0, rnd6(), rnd6(), 1'b0, 1'b1, 3'd3, 4'h0, fl | acc, {tag, "_memwait"});
    cyc(1'b0, rnd6(), rnd6(), 1'b1, 1'b0, 3'd3, 4'h0, fl | acc, {tag, "_memack"});
    if (is_lw)
      cyc(1'b0, rnd6(), rnd6(), 1'b1, 1'b1, 3'd4, 4'h0, fl | RW, {tag, "_wb"});
  endtask

  task automatic run_mul(input int done_at, input string tag);
    run_fetch(tag);
    cyc(1'b0, 6'h1c, 6'h02, 1'b0, 1'b0, 3'd1, 4'h0, MST, {tag, "_decode"});
    if (done_at > 0) begin
      for (int i = 1; i < done_at; i++)
        cyc(1'b0, rnd6(), rnd6(), 1'b1, 1'b0, 3'd5, 4'h2, RD, {tag, "_wait"});
      cyc(1'b0, rnd6(), rnd6(), 1'b0, 1'b1, 3'd5, 4'h2, RD, {tag, "_done"});
      cyc(1'b0, rnd6(), rnd6(), 1'b0, 1'b0, 3'd4, 4'h2, RD | RW, {tag, "_wb"});
    end else begin
      for (int i = 1; i < 32; i++)
        cyc(1'b0, rnd6(), rnd6(), 1'b1, 1'b0, 3'd5, 4'h2, RD, {tag, "_wait"});
      cyc(1'b0, rnd6(), rnd6(), 1'b1, 1'b0, 3'd5, 4'h2, RD | ILL, {tag, "_timeout"});
    end
  endtask

  task automatic run_ill(input logic [5:0] opc, input logic [5:0] fn, input string tag);
    run_fetch(tag);
    cyc(1'b0, opc, fn, 1'b1, 1'b1, 3'd1, 4'h0, ILL, {tag, "_decode"});
  endtask

  task automatic run_bne(input string tag);
    run_fetch(tag);
    cyc(1'b0, 6'h05, rnd6(), 1'b0, 1'b0, 3'd1, 4'h0, NONE, {tag, "_decode"});
    cyc(1'b0, rnd6(), rnd6(), 1'b1, 1'b1, 3'd2, 4'h6, RD | PWC, {tag, "_exec"});
  endtask

  // stimulus
  initial begin
    Rst = 1'b1; opcode = '0; func = '0; mem_ready = 1'b0; mul_done = 1'b0;
    cyc(1'b1, 6'h00, 6'h00, 1'b0, 1'b0, 3'd0, 4'h0, NONE, "reset0");
    cyc(1'b1, 6'h23, 6'h20, 1'b1, 1'b1, 3'd0, 4'h0, NONE, "reset1");

    run_alu(6'h00, 6'h20, 4'h0, RD, "add");
    run_alu(6'h00, 6'h22, 4'h1, RD, "sub");
    run_alu(6'h00, 6'h24, 4'h3, RD, "and");
    run_alu(6'h00, 6'h25, 4'h4, RD, "or");
    run_alu(6'h00, 6'h2a, 4'h5, RD, "slt");
    run_alu(6'h00, 6'h00, 4'h8, RD | AS2 | RSL, "sll");
    run_alu(6'h00, 6'h02, 4'h9, RD | AS2 | RSL, "srl");
    run_alu(6'h00, 6'h06, 4'ha, RD, "rotr");
    run_alu(6'h1c, 6'h21, 4'hb, RD, "clo");
    run_alu(6'h1c, 6'h20, 4'hc, RD, "clz");
    run_alu(6'h08, 6'h3f, 4'h0, AS, "addi");
    run_alu(6'h0d, 6'h02, 4'h4, AS, "ori");

    run_mem(1'b1, 3, "lw_wait3");
    run_mem(1'b1, 0, "lw_fast");
    run_mem(1'b0, 1, "sw_wait1");

    run_mul(5, "mul_done5");
    run_mul(0, "mul_timeout");
    run_mul(1, "mul_done1");

    run_ill(6'h3f, 6'h00, "ill_op3f");
    run_ill(6'h00, 6'h3f, "ill_rfunc");
    run_ill(6'h1c, 6'h01, "ill_sp2func");
    run_bne("bne");

    // reset while a store waits on memory
    run_fetch("rst_sw");
    cyc(1'b0, 6'h2b, 6'h00, 1'b0, 1'b0, 3'd1, 4'h0, NONE, "rst_sw_decode");
    cyc(1'b0, rnd6(), rnd6(), 1'b0, 1'b0, 3'd2, 4'h0, AS, "rst_sw_exec");
    cyc(1'b0, rnd6(), rnd6(), 1'b0, 1'b0, 3'd3, 4'h0, AS | MW, "rst_sw_mem");
    cyc(1'b1, rnd6(), rnd6(), 1'b1, 1'b0, 3'd3, 4'h0, NONE, "rst_sw_assert");
    cyc(1'b1, rnd6(), rnd6(), 1'b1, 1'b1, 3'd0, 4'h0, NONE, "rst_sw_held");
    run_fetch("rst_sw_resume");
    cyc(1'b0, 6'h3f, 6'h3f, 1'b1, 1'b0, 3'd1, 4'h0, ILL, "rst_sw_next");

    // reset while waiting on the multiplier
    run_fetch("rst_mul");
    cyc(1'b0, 6'h1c, 6'h02, 1'b0, 1'b0, 3'd1, 4'h0, MST, "rst_mul_decode");
    cyc(1'b0, rnd6(), rnd6(), 1'b0, 1'b0, 3'd5, 4'h2, RD, "rst_mul_wait");
    cyc(1'b0, rnd6(), rnd6(), 1'b0, 1'b0, 3'd5, 4'h2, RD, "rst_mul_wait");
    cyc(1'b1, rnd6(), rnd6(), 1'b0, 1'b1, 3'd5, 4'h0, NONE, "rst_mul_assert");
    cyc(1'b1, rnd6(), rnd6(), 1'b1, 1'b1, 3'd0, 4'h0, NONE, "rst_mul_held");
    run_alu(6'h00, 6'h20, 4'h0, RD, "rst_mul_resume_add");
    run_fetch("final");

    repeat (2) @(posedge Clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
